// File: rtl/req_capture_4.sv
`default_nettype none
// ============================================================================
// Module   : req_capture_4
// Purpose  : Synchronises four asynchronous request lines and detects events
//            on them. Events are held in sticky pending bits, and the pending
//            requests are presented one at a time as a registered 2-bit index
//            with a valid/ready handshake. Bit 0 has the highest priority.
// Revision : 1.0 - initial release
// ============================================================================
module req_capture_4 #(
  parameter int SYNC_STAGES = 2,  // synchroniser depth per line, 2..4
  parameter int EDGE_MODE   = 1   // 1: rising-edge events, 0: level events
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] i,
  input  logic       y_ready,
  input  logic       ovf_clr,
  output logic [1:0] y,
  output logic       y_valid,
  output logic [3:0] pend,
  output logic       ovf
);

  typedef enum logic [0:0] {
    ST_IDLE    = 1'b0,
    ST_PRESENT = 1'b1
  } state_t;

  state_t     state_q;
  logic [1:0] y_q;
  logic [3:0] pend_q;
  logic [3:0] pend_d;
  logic       ovf_q;
  logic       ovf_d;
  logic [3:0] sync_q [SYNC_STAGES];
  logic [3:0] sp_q;

  logic [3:0] s_w;
  logic [3:0] evt_w;
  logic       acc_w;
  logic [3:0] clr_w;
  logic [3:0] rem_w;
  logic       ovf_set_w;

  // Index of the lowest set bit; bit 0 wins over higher bits.
  function automatic logic [1:0] prio(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    if (v[0])      idx = 2'd0;
    else if (v[1]) idx = 2'd1;
    else if (v[2]) idx = 2'd2;
    else if (v[3]) idx = 2'd3;
    return idx;
  endfunction

  // First synchroniser stage samples the asynchronous lines.
  always_ff @(posedge clk) begin
    if (rst) sync_q[0] <= 4'b0;
    else     sync_q[0] <= i;
  end

  generate
    for (genvar k = 1; k < SYNC_STAGES; k++) begin : g_sync
      // Remaining synchroniser stages shift the sample along the chain.
      always_ff @(posedge clk) begin
        if (rst) sync_q[k] <= 4'b0;
        else     sync_q[k] <= sync_q[k-1];
      end
    end
  endgenerate

  assign s_w = sync_q[SYNC_STAGES-1];

  // Delayed copy of the synchronised lines for edge detection.
  always_ff @(posedge clk) begin
    if (rst) sp_q <= 4'b0;
    else     sp_q <= s_w;
  end

  assign evt_w     = (EDGE_MODE != 0) ? (s_w & ~sp_q) : s_w;
  assign acc_w     = (state_q == ST_PRESENT) && y_ready;
  assign clr_w     = acc_w ? (4'b0001 << y_q) : 4'b0000;
  // Remaining requests once the current acceptance is applied; events
  // arriving this cycle are deliberately excluded.
  assign rem_w     = pend_q & ~clr_w;
  // A new event on the bit being cleared simply re-arms it, so it is not
  // treated as an overflow.
  assign ovf_set_w = (EDGE_MODE != 0) && ((evt_w & pend_q & ~clr_w) != 4'b0);
  assign pend_d    = rem_w | evt_w;
  assign ovf_d     = ovf_set_w | (ovf_q & ~ovf_clr);

  // Sticky pending bits and overflow flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_q <= 4'b0;
      ovf_q  <= 1'b0;
    end else begin
      pend_q <= pend_d;
      ovf_q  <= ovf_d;
    end
  end

  // Presentation FSM: picks the highest-priority pending request and holds
  // it stable until accepted, then moves straight to the next one.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      y_q     <= 2'd0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (pend_q != 4'b0) begin
            y_q     <= prio(pend_q);
            state_q <= ST_PRESENT;
          end
        end
        ST_PRESENT: begin
          if (y_ready) begin
            if (rem_w != 4'b0) begin
              y_q <= prio(rem_w);
            end else begin
              state_q <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign y       = y_q;
  assign y_valid = (state_q == ST_PRESENT);
  assign pend    = pend_q;
  assign ovf     = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_req_capture_4.sv
`default_nettype none
// ============================================================================
// Module   : tb_req_capture_4
// Purpose  : Directed bench for req_capture_4: a cycle table covering reset,
//            single and back-to-back requests, then hand sequences for stall,
//            overflow, event/clear collision, mid-handshake reset and a
//            level-mode, three-stage instance.
// Revision : 1.0 - initial release
// ============================================================================
module tb_req_capture_4;

  logic       clk = 1'b0;
  logic       rst, y_ready, ovf_clr;
  logic [3:0] i;
  logic [1:0] y;
  logic       y_valid, ovf;
  logic [3:0] pend;

  logic       rst_b, y_ready_b, ovf_clr_b;
  logic [3:0] i_b;
  logic [1:0] y_b;
  logic       y_valid_b, ovf_b;
  logic [3:0] pend_b;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  req_capture_4 #(.SYNC_STAGES(2), .EDGE_MODE(1)) u_dut (
    .clk(clk), .rst(rst), .i(i), .y_ready(y_ready), .ovf_clr(ovf_clr),
    .y(y), .y_valid(y_valid), .pend(pend), .ovf(ovf)
  );

  req_capture_4 #(.SYNC_STAGES(3), .EDGE_MODE(0)) u_lvl (
    .clk(clk), .rst(rst_b), .i(i_b), .y_ready(y_ready_b), .ovf_clr(ovf_clr_b),
    .y(y_b), .y_valid(y_valid_b), .pend(pend_b), .ovf(ovf_b)
  );

  typedef struct packed {
    logic       r;
    logic [3:0] iv;
    logic       rd;
    logic       oc;
    logic [1:0] ey;
    logic       ev;
    logic [3:0] ep;
    logic       eo;
  } vec_t;

  localparam int NV = 22;
  vec_t tbl [NV];

  // Apply inputs, let one rising edge pass, sample 1 time unit later.
  task automatic cyc(input logic r, input logic [3:0] iv, input logic rd, input logic oc);
    rst = r; i = iv; y_ready = rd; ovf_clr = oc;
    @(posedge clk);
    #1;
  endtask

  task automatic cyc_b(input logic r, input logic [3:0] iv, input logic rd);
    rst_b = r; i_b = iv; y_ready_b = rd; ovf_clr_b = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [1:0] ey, input logic ev,
                     input logic [3:0] ep, input logic eo);
    total++;
    if (y !== ey || y_valid !== ev || pend !== ep || ovf !== eo) begin
      bad++;
      $display("FAIL %s: got y=%0d vld=%0b pend=%b ovf=%0b, want y=%0d vld=%0b pend=%b ovf=%0b",
               nm, y, y_valid, pend, ovf, ey, ev, ep, eo);
    end
  endtask

  task automatic chk_b(input string nm, input logic [1:0] ey, input logic ev,
                       input logic [3:0] ep);
    total++;
    if (y_b !== ey || y_valid_b !== ev || pend_b !== ep || ovf_b !== 1'b0) begin
      bad++;
      $display("FAIL %s: got y=%0d vld=%0b pend=%b ovf=%0b, want y=%0d vld=%0b pend=%b ovf=0",
               nm, y_b, y_valid_b, pend_b, ovf_b, ey, ev, ep);
    end
  endtask

  initial begin
    rst = 1'b1; i = 4'h0; y_ready = 1'b0; ovf_clr = 1'b0;
    rst_b = 1'b1; i_b = 4'h0; y_ready_b = 1'b0; ovf_clr_b = 1'b0;

    //            rst   i      rdy   oclr  y     vld   pend   ovf
    // T1: reset with all lines high, then four events at once
    tbl[0]  = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[1]  = '{1'b1, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b0, 4'hF, 1'b0};
    tbl[5]  = '{1'b0, 4'hF, 1'b0, 1'b0, 2'd0, 1'b1, 4'hF, 1'b0};
    // drain 0,1,2,3 back-to-back
    tbl[6]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd1, 1'b1, 4'hE, 1'b0};
    tbl[7]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b1, 4'hC, 1'b0};
    tbl[8]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 4'h8, 1'b0};
    tbl[9]  = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0};
    // T2: single pulse on i[2], valid at the fourth edge
    tbl[11] = '{1'b0, 4'h4, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0};
    tbl[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0};
    tbl[13] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h4, 1'b0};
    tbl[14] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b1, 4'h4, 1'b0};
    tbl[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0};
    // T3: two requests together, presented 1 then 3 on consecutive clocks
    tbl[16] = '{1'b0, 4'hA, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0};
    tbl[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 4'h0, 1'b0};
    tbl[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd2, 1'b0, 4'hA, 1'b0};
    tbl[19] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd1, 1'b1, 4'hA, 1'b0};
    tbl[20] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b1, 4'h8, 1'b0};
    tbl[21] = '{1'b0, 4'h0, 1'b1, 1'b0, 2'd3, 1'b0, 4'h0, 1'b0};

    for (int n = 0; n < NV; n++) begin
      cyc(tbl[n].r, tbl[n].iv, tbl[n].rd, tbl[n].oc);
      chk($sformatf("vec%0d", n), tbl[n].ey, tbl[n].ev, tbl[n].ep, tbl[n].eo);
    end

    // T4: stall keeps y=3 while higher-priority bit 0 arrives
    cyc(1'b0, 4'h8, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t4_present", 2'd3, 1'b1, 4'h8, 1'b0);
    cyc(1'b0, 4'h1, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t4_hold_a", 2'd3, 1'b1, 4'h8, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t4_hold_b", 2'd3, 1'b1, 4'h9, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t4_hold_c", 2'd3, 1'b1, 4'h9, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);  chk("t4_acc3", 2'd0, 1'b1, 4'h1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);  chk("t4_acc0", 2'd0, 1'b0, 4'h0, 1'b0);

    // T5: two pulses on i[1] with no acceptance -> overflow
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0);  chk("t5_first", 2'd0, 1'b0, 4'h2, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t5_present", 2'd1, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t5_ovf", 2'd1, 1'b1, 4'h2, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);  chk("t5_ovf_clr", 2'd1, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t5_no_ovf_yet", 2'd1, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);  chk("t5_set_wins", 2'd1, 1'b1, 4'h2, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t5_sticky", 2'd1, 1'b1, 4'h2, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);  chk("t5_clr2", 2'd1, 1'b1, 4'h2, 1'b0);

    // Event and acceptance on the same bit: bit stays set, no overflow
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);  chk("col_evt_wins", 2'd1, 1'b0, 4'h2, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("col_represent", 2'd1, 1'b1, 4'h2, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);  chk("col_drain", 2'd1, 1'b0, 4'h0, 1'b0);

    // T6: reset in the middle of a handshake with overflow set
    cyc(1'b0, 4'h6, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t6_present", 2'd1, 1'b1, 4'h6, 1'b0);
    cyc(1'b0, 4'h2, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);
    cyc(1'b0, 4'h0, 1'b0, 1'b0);  chk("t6_ovf", 2'd1, 1'b1, 4'h6, 1'b1);
    cyc(1'b1, 4'h0, 1'b0, 1'b0);  chk("t6_reset", 2'd0, 1'b0, 4'h0, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);
    cyc(1'b0, 4'h0, 1'b1, 1'b0);  chk("t6_no_stale", 2'd0, 1'b0, 4'h0, 1'b0);

    // Level mode, three sync stages: level re-arms the bit, never overflows
    cyc_b(1'b1, 4'h0, 1'b0);      chk_b("lv_reset", 2'd0, 1'b0, 4'h0);
    cyc_b(1'b0, 4'h4, 1'b0);
    cyc_b(1'b0, 4'h4, 1'b0);
    cyc_b(1'b0, 4'h4, 1'b0);      chk_b("lv_latency", 2'd0, 1'b0, 4'h0);
    cyc_b(1'b0, 4'h4, 1'b0);      chk_b("lv_pend", 2'd0, 1'b0, 4'h4);
    cyc_b(1'b0, 4'h4, 1'b0);      chk_b("lv_present", 2'd2, 1'b1, 4'h4);
    cyc_b(1'b0, 4'h4, 1'b0);      chk_b("lv_no_ovf", 2'd2, 1'b1, 4'h4);
    cyc_b(1'b0, 4'h0, 1'b1);      chk_b("lv_acc_rearm", 2'd2, 1'b0, 4'h4);
    cyc_b(1'b0, 4'h0, 1'b1);      chk_b("lv_again", 2'd2, 1'b1, 4'h4);
    cyc_b(1'b0, 4'h0, 1'b1);      chk_b("lv_acc2", 2'd2, 1'b0, 4'h4);
    cyc_b(1'b0, 4'h0, 1'b1);      chk_b("lv_last", 2'd2, 1'b1, 4'h4);
    cyc_b(1'b0, 4'h0, 1'b1);      chk_b("lv_drained", 2'd2, 1'b0, 4'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
